// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the two-port memory bus arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} ArbState;
    typedef logic PortId;
    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } MemReq;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: requester ports and MMU port of the memory bus arbiter
interface mem_bus_arbiter_if;
    logic        m0_req, m0_we, m0_ack;
    logic [15:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_ack;
    logic [15:0] m1_addr, m1_wdata, m1_rdata;
    logic        mmu_w_en;
    logic [15:0] mmu_addr, mmu_data_w, mmu_data_r;
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata, mmu_data_r,
        output m0_ack, m0_rdata, m1_ack, m1_rdata, mmu_w_en, mmu_addr, mmu_data_w
    );
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata, mmu_data_r,
        input  m0_ack, m0_rdata, m1_ack, m1_rdata, mmu_w_en, mmu_addr, mmu_data_w
    );
endinterface

// File: rtl/arb_age_select.sv
// arb_age_select: fixed-priority winner select with an aging counter that forces a port 1 grant
module arb_age_select
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  req0,
    input  logic  req1,
    input  logic  arb_en,
    output PortId winner,
    output logic  grant_valid
);
    localparam int AGE_W = $clog2(MAX_WAIT + 1);

    logic [AGE_W-1:0] age;

    always_comb begin
        winner      = PortId'(req1 && (!req0 || age == AGE_W'(MAX_WAIT)));
        grant_valid = req0 || req1;
    end

    // age only grows when port 1 loses a contested arbitration
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            age <= '0;
        else if (arb_en && grant_valid)
            age <= winner ? '0 : (req1 && age != AGE_W'(MAX_WAIT)) ? age + 1'b1 : age;
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the MMU memory port between the CPU (port 0) and DMA (port 1),
// sequencing one transaction at a time around the memory read latency
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int READ_LAT = 1,
    parameter int MAX_WAIT = 4
) (
    input logic clk,
    input logic rst,
    mem_bus_arbiter_if.slave bus
);
    localparam int LAT_W = $clog2(READ_LAT + 1);

    ArbState          state, nxt;
    MemReq            lat;
    PortId            pid, winner;
    logic             grant_valid;
    logic [LAT_W-1:0] cnt;
    logic [15:0]      rdata0, rdata1;

    arb_age_select #(.MAX_WAIT(MAX_WAIT)) u_age (
        .clk(clk),
        .rst(rst),
        .req0(bus.m0_req),
        .req1(bus.m1_req),
        .arb_en(state == IDLE),
        .winner(winner),
        .grant_valid(grant_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt            = state;
        bus.m0_ack     = 1'b0;
        bus.m1_ack     = 1'b0;
        bus.mmu_w_en   = 1'b0;
        bus.mmu_addr   = '0;
        bus.mmu_data_w = '0;
        case (state)
            IDLE: nxt = grant_valid ? ISSUE : IDLE;
            ISSUE: begin
                nxt            = lat.we ? RESP : WAIT;
                bus.mmu_w_en   = lat.we;
                bus.mmu_addr   = lat.addr;
                bus.mmu_data_w = lat.wdata;
            end
            WAIT: begin
                nxt          = (cnt == LAT_W'(1)) ? RESP : WAIT;
                bus.mmu_addr = lat.addr;
            end
            RESP: begin
                nxt        = IDLE;
                bus.m0_ack = !pid;
                bus.m1_ack = pid;
            end
            default: nxt = IDLE;
        endcase
    end

    // the request is latched at grant so a requester dropping req early cannot disturb the bus
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat    <= '0;
            pid    <= '0;
            cnt    <= '0;
            rdata0 <= '0;
            rdata1 <= '0;
        end else begin
            if (state == IDLE && grant_valid) begin
                lat <= winner ? {bus.m1_we, bus.m1_addr, bus.m1_wdata}
                              : {bus.m0_we, bus.m0_addr, bus.m0_wdata};
                pid <= winner;
            end
            if (state == ISSUE)
                cnt <= LAT_W'(READ_LAT);
            if (state == WAIT) begin
                cnt <= cnt - 1'b1;
                if (cnt == LAT_W'(1) && pid)
                    rdata1 <= bus.mmu_data_r;
                if (cnt == LAT_W'(1) && !pid)
                    rdata0 <= bus.mmu_data_r;
            end
        end
    end

    assign bus.m0_rdata = rdata0;
    assign bus.m1_rdata = rdata1;
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single MMU memory port (ROM / UART / RAM decode) between two requesters.
- Port 0 is the CPU load/store unit; port 1 is the DMA/boot-loader engine.
- Sequences each transaction with the synchronous memories' read latency and returns a one-cycle ack with read data.
- Sits directly in front of the MMU; all MMU inputs are driven only by this block.

Parameters:
- READ_LAT, 1, ph0 cycles from the MMU address being presented to mmu_data_r being valid (≥1).
- MAX_WAIT, 4, consecutive arbitration losses by port 1 before it is forced a grant (≥1).

Ports:
- clk  in  Clock  system clock struct; all state updates on rising edge of clk.ph0.
- rst  in  1  asynchronous, active-high reset.
- m0_req  in  1  port 0 request; held high with fields stable until m0_ack.
- m0_we  in  1  port 0 write (1) / read (0).
- m0_addr  in  16  port 0 byte address.
- m0_wdata  in  16  port 0 write data.
- m0_ack  out  1  one-cycle completion pulse.
- m0_rdata  out  16  read data, valid while m0_ack=1.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata  same as port 0, for port 1.
- mmu_w_en  out  1  to MMU w_en.
- mmu_addr  out  16  to MMU addr.
- mmu_data_w  out  16  to MMU data_w.
- mmu_data_r  in  16  from MMU data_r.

Behaviour:
- Reset (async):
  - state=IDLE; age=0.
  - All outputs 0: acks, rdata, mmu_w_en, mmu_addr, mmu_data_w.
  - Reset mid-transaction aborts it; no ack is issued afterwards. A write already on the bus may or may not land.
- FSM states: IDLE, ISSUE, WAIT, RESP. Only one transaction is outstanding at a time.
- IDLE:
  - If any req is high at the edge, latch the winner's {we, addr, wdata} and port id, then go to ISSUE.
  - Otherwise stay in IDLE.
  - MMU outputs are 0.
- ISSUE (1 cycle):
  - mmu_addr and mmu_data_w come from the latch.
  - mmu_w_en = latched we.
  - Write goes to RESP. Read goes to WAIT with counter = READ_LAT.
- WAIT:
  - mmu_addr held; mmu_w_en=0.
  - Counter decrements each cycle.
  - At the edge where the counter reaches 1, capture mmu_data_r into the winner's rdata register and go to RESP.
- RESP (1 cycle):
  - The winner's ack=1; rdata is valid for reads and holds its last value for writes.
  - MMU outputs return to 0.
  - Next state is IDLE.
- Latency, with req sampled at edge 0:
  - Write: ack high during cycle 2.
  - Read: ack high during cycle 2+READ_LAT.
  - Minimum spacing between grants is 3 cycles (write) or 3+READ_LAT cycles (read).
- mmu_w_en is high only in ISSUE of a write; never high in any other state.
- Arbitration, evaluated in IDLE only:
  - Only one req high: that port wins.
  - Both high and age==MAX_WAIT: port 1 wins, age←0.
  - Both high, otherwise: port 0 wins, age←age+1 (saturating at MAX_WAIT).
  - Whenever port 1 wins: age←0.
  - Neither req high: age unchanged.
  - age width is $clog2(MAX_WAIT+1).
- Request rules:
  - A req dropped before its ack (protocol violation) does not cancel the transaction; the ack is still pulsed.
  - A req still high in the cycle after its ack is treated as a new request.
  - The non-winning port's ack stays 0 throughout.
  - Its rdata is unchanged.
- Address wrap: addr is passed through unmodified; decode is the MMU's job.

Decomposition:
- Package mem_arb_pkg holds:
  - ArbState enum {IDLE, ISSUE, WAIT, RESP}.
  - MemReq packed struct {we, addr[15:0], wdata[15:0]}.
  - Port-id typedef (1 bit).
- Sub-module arb_age_select: combinational winner selection plus the registered age counter. Inputs: req0, req1, arb_en, clk, rst. Outputs: winner, grant_valid.

Test Plan:
- Port 0 writes 0xBEEF to 0x8010, port 1 idle → mmu_w_en=1 for exactly one cycle with addr=0x8010 and data_w=0xBEEF; m0_ack pulses in cycle 2; m1_ack stays 0.
- Port 1 reads 0x0100, READ_LAT=1, MMU returns 0x1234 → m1_ack in cycle 3 with m1_rdata=0x1234; mmu_w_en stays 0 throughout.
- Both ports hold continuous reads, MAX_WAIT=4 → grant order is 0,0,0,0,1,0,0,0,0,1; no ack overlaps another.
- Both ports request in the same IDLE cycle with age=0 → port 0 wins; age=1; port 1 is served after port 0's RESP.
- rst asserted during a WAIT cycle → all outputs 0 immediately; no ack follows; a fresh request after reset completes normally.
- Run with READ_LAT=3 → a read ack arrives 5 cycles after req; mmu_addr stays stable for all 4 ISSUE+WAIT cycles.
